// File: rtl/rifl_tx_packer.sv
// rifl_tx_packer: classifies user AXI-Stream beats, encodes them into {meta, data} words
// and buffers them in a small register FIFO ahead of the RIFL TX controller.
module rifl_tx_packer #(
    parameter int unsigned PAYLOAD_WIDTH = 240,
    parameter int unsigned FIFO_AW       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PAYLOAD_WIDTH-1:0]   s_axis_tdata,
    input  logic [PAYLOAD_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       rifl_tx_ready,
    output logic [PAYLOAD_WIDTH+1:0]   rifl_tx_payload,
    output logic [FIFO_AW:0]           fifo_level,
    output logic                       keep_error,
    output logic [31:0]                frame_cnt,
    output logic [31:0]                pkt_cnt
);

    localparam int unsigned KeepW = PAYLOAD_WIDTH / 8;
    localparam int unsigned WordW = PAYLOAD_WIDTH + 2;
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned CntW  = $clog2(KeepW + 1);

    localparam logic [1:0] MetaNone = 2'b00;
    localparam logic [1:0] MetaLast = 2'b01;  // last, partial
    localparam logic [1:0] MetaFull = 2'b10;  // last, all bytes valid
    localparam logic [1:0] MetaData = 2'b11;  // data, not last

    logic [WordW-1:0]         mem_q [Depth];
    logic [FIFO_AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]         level_q, level_d;
    logic                     keep_error_q;
    logic [31:0]              frame_cnt_q, pkt_cnt_q;

    logic [CntW-1:0]          keep_cnt;
    logic                     keep_contig;
    logic [PAYLOAD_WIDTH-1:0] enc_data;
    logic [1:0]               enc_meta;
    logic                     fifo_empty, fifo_full;
    logic                     beat_hs, push, pop;
    logic [1:0]               head_meta;

    // Classify the incoming beat and build its encoded FIFO word.
    always_comb begin
        keep_cnt    = '0;
        keep_contig = 1'b1;
        enc_data    = '0;
        enc_meta    = MetaNone;
        for (int i = 0; i < KeepW; i++) begin
            keep_cnt = keep_cnt + CntW'(s_axis_tkeep[i]);
        end
        // Contiguous from LSB means bit i is set exactly when i < popcount.
        for (int i = 0; i < KeepW; i++) begin
            if ((CntW'(i) < keep_cnt) != s_axis_tkeep[i]) begin
                keep_contig = 1'b0;
            end
        end
        for (int i = 0; i < KeepW; i++) begin
            enc_data[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
        end
        if (&s_axis_tkeep) begin
            enc_data = s_axis_tdata;
            enc_meta = s_axis_tlast ? MetaFull : MetaData;
        end else if (s_axis_tlast && keep_contig && (keep_cnt != '0)) begin
            // Top byte is always invalid in a partial frame, so the count fits there.
            enc_data[PAYLOAD_WIDTH-1 -: 8] = 8'(keep_cnt);
            enc_meta = MetaLast;
        end
    end

    assign fifo_empty    = (level_q == '0);
    assign fifo_full     = (level_q == (FIFO_AW+1)'(Depth));
    assign s_axis_tready = ~rst & ~fifo_full;
    assign beat_hs       = s_axis_tvalid & s_axis_tready;
    assign push          = beat_hs & (enc_meta != MetaNone);
    assign pop           = rifl_tx_ready & ~fifo_empty;
    assign head_meta     = mem_q[rd_ptr_q][WordW-1 -: 2];

    // Level tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointers, level, sticky error and consumption counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            keep_error_q <= 1'b0;
            frame_cnt_q  <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                frame_cnt_q <= frame_cnt_q + 32'd1;
                if (head_meta == MetaFull || head_meta == MetaLast) begin
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                end
            end
            if (beat_hs && enc_meta == MetaNone) begin
                keep_error_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while empty since the output is gated.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {enc_meta, enc_data};
        end
    end

    assign rifl_tx_payload = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level      = level_q;
    assign keep_error      = keep_error_q;
    assign frame_cnt       = frame_cnt_q;
    assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_rifl_tx_packer.sv
// Directed testbench for rifl_tx_packer with immediate-assertion checks.
module tb_rifl_tx_packer;

    localparam int unsigned PW    = 240;
    localparam int unsigned KW    = PW / 8;
    localparam int unsigned AW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [PW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            rifl_tx_ready;
    logic [PW+1:0]   rifl_tx_payload;
    logic [AW:0]     fifo_level;
    logic            keep_error;
    logic [31:0]     frame_cnt;
    logic [31:0]     pkt_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    rifl_tx_packer #(.PAYLOAD_WIDTH(PW), .FIFO_AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .rifl_tx_ready   (rifl_tx_ready),
        .rifl_tx_payload (rifl_tx_payload),
        .fifo_level      (fifo_level),
        .keep_error      (keep_error),
        .frame_cnt       (frame_cnt),
        .pkt_cnt         (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0]   d1, d2, dt;
    logic [PW+1:0]   exp_w;
    logic [PW+1:0]   model_q[$];
    logic [KW-1:0]   all_ones;
    int              acc, idx, popped, cyc;
    logic            acc_now, pop_now;

    initial begin
        all_ones      = '1;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        rifl_tx_ready = 1'b0;
        tick();
        chk("tready_in_reset", 256'(s_axis_tready), 256'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("reset_level", 256'(fifo_level), 256'd0);
        chk("reset_payload", 256'(rifl_tx_payload), 256'd0);
        chk("reset_counters", 256'({frame_cnt, pkt_cnt}), 256'd0);
        chk("reset_keep_error", 256'(keep_error), 256'd0);
        chk("tready_after_reset", 256'(s_axis_tready), 256'd1);

        // Single full last beat, consumed the cycle after it lands.
        d1 = {{7{32'hDEADBEEF}}, 16'hCAFE};
        s_axis_tdata  = d1;
        s_axis_tkeep  = all_ones;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        rifl_tx_ready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        chk("t1_payload", 256'(rifl_tx_payload), 256'({2'b10, d1}));
        chk("t1_level", 256'(fifo_level), 256'd1);
        tick();
        chk("t1_frame_cnt", 256'(frame_cnt), 256'd1);
        chk("t1_pkt_cnt", 256'(pkt_cnt), 256'd1);
        chk("t1_empty_payload", 256'(rifl_tx_payload), 256'd0);
        // Ready while empty must not count.
        tick();
        chk("empty_ready_frame_cnt", 256'(frame_cnt), 256'd1);
        chk("empty_ready_level", 256'(fifo_level), 256'd0);

        // Partial last beat: 3 valid bytes, junk above must be zeroed.
        rifl_tx_ready = 1'b0;
        s_axis_tdata  = {{27{8'h5A}}, 24'hAABBCC};
        s_axis_tkeep  = KW'(3'b111);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        d2 = {8'd3, 208'd0, 24'hAABBCC};
        chk("t2_payload", 256'(rifl_tx_payload), 256'({2'b01, d2}));
        rifl_tx_ready = 1'b1;
        tick();
        rifl_tx_ready = 1'b0;
        chk("t2_pkt_cnt", 256'(pkt_cnt), 256'd2);
        chk("t2_frame_cnt", 256'(frame_cnt), 256'd2);

        // Malformed keeps: non-contiguous, partial without tlast, empty keep.
        s_axis_tdata  = '1;
        s_axis_tkeep  = KW'(3'b101);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        tick();
        chk("t4_keep_error", 256'(keep_error), 256'd1);
        chk("t4_level_noncontig", 256'(fifo_level), 256'd0);
        s_axis_tkeep  = KW'(2'b11);
        s_axis_tlast  = 1'b0;
        tick();
        chk("t4_level_partial_nolast", 256'(fifo_level), 256'd0);
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b1;
        tick();
        chk("t4_level_zero_keep", 256'(fifo_level), 256'd0);
        s_axis_tvalid = 1'b0;
        tick();
        chk("t4_keep_error_sticky", 256'(keep_error), 256'd1);

        // Fill with ready low: 20 offered, exactly 16 accepted.
        acc = 0;
        s_axis_tkeep  = all_ones;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = PW'(100 + acc);
            #1;
            acc_now = s_axis_tready;
            tick();
            if (acc_now) acc++;
        end
        s_axis_tvalid = 1'b0;
        chk("t3_accepted", 256'(acc), 256'd16);
        chk("t3_level_full", 256'(fifo_level), 256'd16);
        chk("t3_tready_full", 256'(s_axis_tready), 256'd0);
        rifl_tx_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("t3_drain_%0d", j), 256'(rifl_tx_payload), 256'({2'b11, PW'(100 + j)}));
            tick();
        end
        rifl_tx_ready = 1'b0;
        chk("t3_level_drained", 256'(fifo_level), 256'd0);
        chk("t3_frame_cnt", 256'(frame_cnt), 256'd18);

        // Full-rate push with ready toggling; queue models FIFO contents.
        idx = 0;
        popped = 0;
        cyc = 0;
        model_q.delete();
        while ((idx < 24 || model_q.size() > 0) && cyc < 200) begin
            dt = {8'(idx), 224'd0, 8'(idx ^ 8'hA5)};
            s_axis_tdata  = dt;
            s_axis_tkeep  = all_ones;
            s_axis_tlast  = (idx % 4 == 3);
            s_axis_tvalid = (idx < 24);
            rifl_tx_ready = cyc[0];
            #1;
            acc_now = s_axis_tvalid && s_axis_tready;
            pop_now = rifl_tx_ready && (model_q.size() > 0);
            exp_w   = {s_axis_tlast ? 2'b10 : 2'b11, dt};
            if (pop_now) begin
                chk($sformatf("t5_pop_%0d", popped), 256'(rifl_tx_payload), 256'(model_q[0]));
                void'(model_q.pop_front());
                popped++;
            end
            if (acc_now) begin
                model_q.push_back(exp_w);
                idx++;
            end
            tick();
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        rifl_tx_ready = 1'b0;
        chk("t5_finished_in_budget", 256'(cyc < 200), 256'd1);
        chk("t5_popped", 256'(popped), 256'd24);
        chk("t5_frame_cnt", 256'(frame_cnt), 256'd42);
        chk("t5_pkt_cnt", 256'(pkt_cnt), 256'd8);
        chk("t5_level", 256'(fifo_level), 256'd0);

        // Reset mid-packet with 5 words held.
        s_axis_tkeep  = all_ones;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = PW'(500 + i);
            tick();
        end
        chk("t6_level_before", 256'(fifo_level), 256'd5);
        rst = 1'b1;
        #1;
        chk("t6_tready_in_reset", 256'(s_axis_tready), 256'd0);
        tick();
        chk("t6_level", 256'(fifo_level), 256'd0);
        chk("t6_payload", 256'(rifl_tx_payload), 256'd0);
        chk("t6_counters", 256'({frame_cnt, pkt_cnt}), 256'd0);
        chk("t6_keep_error", 256'(keep_error), 256'd0);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
